// File: rtl/wb_write_arbiter_if.sv
// Writeback port bundle: pipeline/long-latency producers on one side,
// register-file write port, forwarding selects and hazard feedback on the other.
interface wb_write_arbiter_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 2
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic              pipe_we_i;
   logic [4:0]        pipe_rd_i;
   logic [XLEN-1:0]   pipe_data_i;
   logic              lu_valid_i;
   logic [4:0]        lu_rd_i;
   logic [XLEN-1:0]   lu_data_i;
   logic              lu_ready_o;
   logic [4:0]        dec_r1_addr_i;
   logic [4:0]        dec_r2_addr_i;
   logic              rf_rw_en_o;
   logic [4:0]        rd_addr_o;
   logic [XLEN-1:0]   wb_data_o;
   logic              fwd_a_o;
   logic              fwd_b_o;
   logic              stall_o;
   logic [CNT_W-1:0]  pend_cnt_o;

   // Arbiter side.
   modport slave (
      input  pipe_we_i, pipe_rd_i, pipe_data_i,
      input  lu_valid_i, lu_rd_i, lu_data_i,
      input  dec_r1_addr_i, dec_r2_addr_i,
      output lu_ready_o, rf_rw_en_o, rd_addr_o, wb_data_o,
      output fwd_a_o, fwd_b_o, stall_o, pend_cnt_o
   );

   // Producer / consumer side.
   modport master (
      output pipe_we_i, pipe_rd_i, pipe_data_i,
      output lu_valid_i, lu_rd_i, lu_data_i,
      output dec_r1_addr_i, dec_r2_addr_i,
      input  lu_ready_o, rf_rw_en_o, rd_addr_o, wb_data_o,
      input  fwd_a_o, fwd_b_o, stall_o, pend_cnt_o
   );
endinterface

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: merges in-order pipeline results with
// long-latency results buffered in a small FIFO, with starvation-driven stall.
module wb_write_arbiter #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned DEPTH      = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   wb_write_arbiter_if.slave  bus
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

   logic [XLEN-1:0]  mem_data [DEPTH];
   logic [4:0]       mem_rd   [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [STV_W-1:0] starve;

   logic             empty;
   logic             full;
   logic             stall;
   logic             lu_ready;
   logic             fire;
   logic             pipe_claim;
   logic             rf_en;
   logic [4:0]       rd_addr;
   logic [XLEN-1:0]  wb_data;
   logic             pop;
   logic             push;
   logic             bypass;
   logic             own_pipe;

   assign empty      = (count == '0);
   assign full       = (count == CNT_W'(DEPTH));
   assign stall      = !rst_i && (starve == STV_W'(STARVE_MAX)) && !empty;
   assign lu_ready   = !rst_i && !full;
   assign fire       = bus.lu_valid_i && lu_ready;
   assign pipe_claim = bus.pipe_we_i && (bus.pipe_rd_i != 5'd0);

   // Port owner selection; a starved FIFO head beats the pipeline.
   always_comb begin
      rf_en    = 1'b0;
      rd_addr  = 5'd0;
      wb_data  = '0;
      pop      = 1'b0;
      push     = 1'b0;
      bypass   = 1'b0;
      own_pipe = 1'b0;
      if (!rst_i) begin
         if (stall) begin
            rf_en   = 1'b1;
            rd_addr = mem_rd[rd_ptr];
            wb_data = mem_data[rd_ptr];
            pop     = 1'b1;
         end else if (pipe_claim) begin
            rf_en    = 1'b1;
            rd_addr  = bus.pipe_rd_i;
            wb_data  = bus.pipe_data_i;
            own_pipe = 1'b1;
         end else if (!empty) begin
            rf_en   = 1'b1;
            rd_addr = mem_rd[rd_ptr];
            wb_data = mem_data[rd_ptr];
            pop     = 1'b1;
         end else if (fire && (bus.lu_rd_i != 5'd0)) begin
            rf_en   = 1'b1;
            rd_addr = bus.lu_rd_i;
            wb_data = bus.lu_data_i;
            bypass  = 1'b1;
         end
         // x0 results are acknowledged but never stored.
         push = fire && (bus.lu_rd_i != 5'd0) && !bypass;
      end
   end

   assign bus.rf_rw_en_o = rf_en;
   assign bus.rd_addr_o  = rd_addr;
   assign bus.wb_data_o  = wb_data;
   assign bus.fwd_a_o    = rf_en && (rd_addr == bus.dec_r1_addr_i) && (bus.dec_r1_addr_i != 5'd0);
   assign bus.fwd_b_o    = rf_en && (rd_addr == bus.dec_r2_addr_i) && (bus.dec_r2_addr_i != 5'd0);
   assign bus.stall_o    = stall;
   assign bus.lu_ready_o = lu_ready;
   assign bus.pend_cnt_o = count;

   // FIFO control and starvation counter.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         starve <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
         if (empty || pop)
            starve <= '0;
         else if (own_pipe && (starve != STV_W'(STARVE_MAX)))
            starve <= starve + STV_W'(1);
      end
   end

   // Storage carries no reset; validity is tracked by count.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_rd[wr_ptr]   <= bus.lu_rd_i;
         mem_data[wr_ptr] <= bus.lu_data_i;
      end
   end
endmodule
